// File: rtl/axi_delay_sched.sv
// axi_delay_sched: gates per-channel valid/ready for a fixed or LFSR-random delay and counts stall cycles
module axi_delay_sched #(
    parameter int          NumChan    = 5,
    parameter int          DelayWidth = 4,
    parameter logic [15:0] LfsrSeed   = 16'hACE1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic [NumChan*DelayWidth-1:0] delay_i,
    input  logic [NumChan-1:0]            rand_en_i,
    input  logic                          stall_clr_i,
    input  logic [NumChan-1:0]            valid_i,
    output logic [NumChan-1:0]            ready_o,
    output logic [NumChan-1:0]            valid_o,
    input  logic [NumChan-1:0]            ready_i,
    output logic [31:0]                   stall_cnt_o
);
    typedef enum logic [1:0] {IDLE, COUNT, GRANT} state_e;
    state_e                st_q  [NumChan];
    state_e                st_d  [NumChan];
    logic [DelayWidth-1:0] cnt_q [NumChan];
    logic [DelayWidth-1:0] cnt_d [NumChan];
    logic [DelayWidth-1:0] ld    [NumChan];
    logic [15:0]           lfsr_q, lfsr_d;
    logic [31:0]           stall_cnt_q, stall_cnt_d;
    logic [NumChan-1:0]    grant, hs;
    assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    always_comb begin
        for (int i = 0; i < NumChan; i++) begin
            ld[i] = rand_en_i[i] ? (lfsr_q[DelayWidth-1:0] & delay_i[i*DelayWidth +: DelayWidth])
                                 : delay_i[i*DelayWidth +: DelayWidth];
            grant[i] = !enable_i || (st_q[i] == IDLE && valid_i[i] && ld[i] == '0)
                    || (st_q[i] == COUNT && cnt_q[i] == '0) || st_q[i] == GRANT;
            hs[i] = valid_i[i] & ready_i[i] & grant[i];
            st_d[i] = st_q[i];
            cnt_d[i] = cnt_q[i];
            // once valid_o is shown it must stay up until the handshake, hence GRANT
            if (!enable_i) st_d[i] = (valid_i[i] && !ready_i[i]) ? GRANT : IDLE;
            else if (hs[i]) st_d[i] = IDLE;
            else if (grant[i] && valid_i[i]) st_d[i] = GRANT;
            else if (st_q[i] == IDLE && valid_i[i]) begin
                st_d[i] = COUNT;
                cnt_d[i] = ld[i] - DelayWidth'(1);
            end
            else if (st_q[i] == COUNT && cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - DelayWidth'(1);
        end
    end
    assign valid_o = rst_i ? '0 : valid_i & grant;
    assign ready_o = rst_i ? '0 : ready_i & grant;
    assign stall_cnt_d = stall_clr_i ? '0
                       : (|(valid_i & ~grant) && stall_cnt_q != '1) ? stall_cnt_q + 32'd1
                       : stall_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= LfsrSeed;
            stall_cnt_q <= '0;
            for (int i = 0; i < NumChan; i++) begin
                st_q[i] <= IDLE;
                cnt_q[i] <= '0;
            end
        end else begin
            lfsr_q <= lfsr_d;
            stall_cnt_q <= stall_cnt_d;
            st_q <= st_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_axi_delay_sched.sv
// tb_axi_delay_sched: scenario tasks plus randomized delays checked against an LFSR reference model
module tb_axi_delay_sched;
    localparam int NC = 5;
    localparam int DW = 4;
    logic clk = 0;
    logic rst_i = 1;
    logic enable_i = 1;
    logic stall_clr_i = 0;
    logic [NC*DW-1:0] delay_i = '0;
    logic [NC-1:0] rand_en_i = '0;
    logic [NC-1:0] valid_i = '0;
    logic [NC-1:0] ready_i = '0;
    logic [NC-1:0] ready_o, valid_o;
    logic [31:0] stall_cnt_o;
    logic [15:0] ref_lfsr;
    int n_vec = 0;
    int n_err = 0;

    axi_delay_sched #(.NumChan(NC), .DelayWidth(DW), .LfsrSeed(16'hACE1)) dut (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .delay_i(delay_i),
        .rand_en_i(rand_en_i), .stall_clr_i(stall_clr_i), .valid_i(valid_i),
        .ready_o(ready_o), .valid_o(valid_o), .ready_i(ready_i), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    // Fibonacci LFSR for x^16+x^14+x^13+x^11+1: taps at exponent k read bit 16-k, shifted in at the top
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        int taps [4] = '{16, 14, 13, 11};
        logic fb = 1'b0;
        foreach (taps[t]) fb ^= s[16 - taps[t]];
        return {fb, s[15:1]};
    endfunction

    always @(posedge clk) ref_lfsr <= rst_i ? 16'hACE1 : lfsr_next(ref_lfsr);

    task automatic set_delay(input int ch, input int v);
        delay_i[ch*DW +: DW] = DW'(v);
    endtask

    task automatic clear_stall();
        @(negedge clk); valid_i = '0; ready_i = '0; enable_i = 1; stall_clr_i = 1;
        @(negedge clk); stall_clr_i = 0;
    endtask

    task automatic test_reset();
        rst_i = 1; enable_i = 0; valid_i = '1; ready_i = '1;
        @(negedge clk); #1;
        n_vec++; if (valid_o !== '0) begin n_err++; $display("FAIL rst_valid_o: got %b want 0", valid_o); end
        n_vec++; if (ready_o !== '0) begin n_err++; $display("FAIL rst_ready_o: got %b want 0", ready_o); end
        @(negedge clk); #1;
        n_vec++; if (stall_cnt_o !== 32'd0) begin n_err++; $display("FAIL rst_stall: got %0h want 0", stall_cnt_o); end
        @(negedge clk); rst_i = 0; valid_i = '0; ready_i = '0; enable_i = 1;
    endtask

    task automatic test_pass_through();
        int hs_n = 0;
        clear_stall();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); enable_i = 0; valid_i[0] = 1; ready_i[0] = 1; #1;
            n_vec++; if (valid_o !== valid_i) begin n_err++; $display("FAIL pt_valid c%0d: got %b want %b", c, valid_o, valid_i); end
            if (valid_o[0] && ready_i[0]) hs_n++;
        end
        @(negedge clk); valid_i = '0; ready_i = '0; #1;
        n_vec++; if (hs_n !== 10) begin n_err++; $display("FAIL pt_hs_count: got %0d want 10", hs_n); end
        n_vec++; if (stall_cnt_o !== 32'd0) begin n_err++; $display("FAIL pt_stall: got %0d want 0", stall_cnt_o); end
        @(negedge clk); set_delay(0, 5); enable_i = 0; valid_i[0] = 1; ready_i[0] = 0; #1;
        n_vec++; if (valid_o[0] !== 1'b1) begin n_err++; $display("FAIL pt_pending: got %b want 1", valid_o[0]); end
        @(negedge clk); enable_i = 1; #1;
        n_vec++; if (valid_o[0] !== 1'b1) begin n_err++; $display("FAIL en_rise_hold: got %b want 1", valid_o[0]); end
        @(negedge clk); ready_i[0] = 1; #1;
        n_vec++; if (ready_o[0] !== 1'b1) begin n_err++; $display("FAIL en_rise_hs: got %b want 1", ready_o[0]); end
        @(negedge clk); valid_i = '0; ready_i = '0; #1;
        n_vec++; if (valid_o !== '0) begin n_err++; $display("FAIL en_rise_after: got %b want 0", valid_o); end
    endtask

    task automatic test_fixed_delay();
        clear_stall();
        set_delay(1, 3); rand_en_i = '0; ready_i = '1;
        for (int c = 0; c < 4; c++) begin
            logic e;
            @(negedge clk); valid_i[1] = 1; #1;
            e = (c == 3);
            n_vec++; if (valid_o[1] !== e) begin n_err++; $display("FAIL fix_valid c%0d: got %b want %b", c, valid_o[1], e); end
            n_vec++; if (ready_o[1] !== e) begin n_err++; $display("FAIL fix_ready c%0d: got %b want %b", c, ready_o[1], e); end
        end
        @(negedge clk); valid_i = '0; #1;
        n_vec++; if (stall_cnt_o !== 32'd3) begin n_err++; $display("FAIL fix_stall: got %0d want 3", stall_cnt_o); end
    endtask

    task automatic test_backpressure();
        clear_stall();
        set_delay(2, 2);
        for (int c = 0; c < 10; c++) begin
            logic e;
            @(negedge clk); valid_i[2] = (c <= 8); ready_i[2] = (c >= 8); #1;
            e = (c >= 2 && c <= 8);
            n_vec++; if (valid_o[2] !== e) begin n_err++; $display("FAIL bp_valid c%0d: got %b want %b", c, valid_o[2], e); end
            if (c == 8) begin
                n_vec++; if (ready_o[2] !== 1'b1) begin n_err++; $display("FAIL bp_hs: got %b want 1", ready_o[2]); end
            end
            if (c == 9) begin
                n_vec++; if (stall_cnt_o !== 32'd2) begin n_err++; $display("FAIL bp_stall: got %0d want 2", stall_cnt_o); end
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_stall();
        set_delay(1, 1); set_delay(2, 2); set_delay(4, 0);
        for (int c = 0; c < 9; c++) begin
            logic [NC-1:0] e;
            @(negedge clk); valid_i = 5'b10110; ready_i = 5'b10110; #1;
            e = '0; e[4] = 1'b1; e[1] = (c % 2 == 1); e[2] = (c % 3 == 2);
            n_vec++; if (valid_o !== e) begin n_err++; $display("FAIL b2b_valid c%0d: got %b want %b", c, valid_o, e); end
            n_vec++; if (ready_o !== e) begin n_err++; $display("FAIL b2b_ready c%0d: got %b want %b", c, ready_o, e); end
        end
        @(negedge clk); valid_i = '0; ready_i = '0;
    endtask

    task automatic test_enable_drop();
        clear_stall();
        set_delay(3, 7); ready_i = '1;
        for (int c = 0; c < 6; c++) begin
            logic e;
            @(negedge clk); valid_i[3] = 1; enable_i = (c != 3);
            if (c == 4) set_delay(3, 1);
            #1;
            e = (c == 3 || c == 5);
            n_vec++; if (valid_o[3] !== e) begin n_err++; $display("FAIL endrop_valid c%0d: got %b want %b", c, valid_o[3], e); end
        end
        @(negedge clk); valid_i = '0; ready_i = '0; enable_i = 1;
    endtask

    task automatic test_reset_mid();
        clear_stall();
        set_delay(1, 3); ready_i = '1;
        for (int c = 0; c < 6; c++) begin
            logic e;
            @(negedge clk); valid_i[1] = 1; rst_i = (c == 1); #1;
            e = (c == 5);
            n_vec++; if (valid_o[1] !== e) begin n_err++; $display("FAIL rstmid_valid c%0d: got %b want %b", c, valid_o[1], e); end
        end
        @(negedge clk); valid_i = '0; ready_i = '0;
    endtask

    task automatic test_random();
        clear_stall();
        for (int n = 0; n < 200; n++) begin
            int k;
            int rw;
            logic [3:0] mask, exp_d;
            mask = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            rw = $urandom_range(0, 2);
            @(negedge clk);
            set_delay(0, int'(mask)); rand_en_i[0] = 1; valid_i[0] = 1; ready_i[0] = (rw == 0);
            exp_d = ref_lfsr[3:0] & mask;
            #1; k = 0;
            while (valid_o[0] !== 1'b1 && k < 40) begin @(negedge clk); #1; k++; end
            n_vec++; if (k !== int'(exp_d)) begin n_err++; $display("FAIL rnd_delay n%0d: got %0d want %0d", n, k, exp_d); end
            for (int j = 0; j < rw; j++) begin
                n_vec++; if (valid_o[0] !== 1'b1) begin n_err++; $display("FAIL rnd_hold n%0d: got %b want 1", n, valid_o[0]); end
                @(negedge clk); if (j == rw - 1) ready_i[0] = 1; #1;
            end
            n_vec++; if (ready_o[0] !== 1'b1) begin n_err++; $display("FAIL rnd_hs n%0d: got %b want 1", n, ready_o[0]); end
            if ($urandom_range(0, 3) == 0) begin @(negedge clk); valid_i[0] = 0; ready_i[0] = 0; end
        end
        @(negedge clk); valid_i = '0; ready_i = '0; rand_en_i = '0;
    endtask

    task automatic test_saturation();
        clear_stall();
        set_delay(1, 7); rand_en_i = '0; ready_i = '1;
        @(negedge clk); valid_i[1] = 1; force dut.stall_cnt_d = 32'hFFFF_FFFE;
        @(negedge clk); release dut.stall_cnt_d; #1;
        n_vec++; if (stall_cnt_o !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL sat_preload: got %0h want fffffffe", stall_cnt_o); end
        for (int c = 2; c < 5; c++) begin
            @(negedge clk); stall_clr_i = (c == 4); #1;
            n_vec++; if (stall_cnt_o !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sat_hold c%0d: got %0h want ffffffff", c, stall_cnt_o); end
        end
        @(negedge clk); stall_clr_i = 0; #1;
        n_vec++; if (stall_cnt_o !== 32'd0) begin n_err++; $display("FAIL sat_clear: got %0h want 0", stall_cnt_o); end
        @(negedge clk); #1;
        n_vec++; if (stall_cnt_o !== 32'd1) begin n_err++; $display("FAIL sat_resume: got %0h want 1", stall_cnt_o); end
        @(negedge clk); #1;
        n_vec++; if (valid_o[1] !== 1'b1) begin n_err++; $display("FAIL sat_grant: got %b want 1", valid_o[1]); end
        n_vec++; if (stall_cnt_o !== 32'd2) begin n_err++; $display("FAIL sat_cnt2: got %0h want 2", stall_cnt_o); end
        @(negedge clk); valid_i = '0; #1;
        n_vec++; if (stall_cnt_o !== 32'd2) begin n_err++; $display("FAIL sat_final: got %0h want 2", stall_cnt_o); end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_fixed_delay();
        test_backpressure();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
        $fatal(1);
    end
endmodule
